instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded at reset (bits [1:0] forced to 0).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-005 SHALL have port imem_req_addr, output, 32, word-aligned fetch address.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-007 SHALL have port imem_resp_valid, input, 1, returned instruction valid.
REQ-008 SHALL have port imem_resp_data, input, 32, returned instruction word.
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc, input, 32, redirect target.
REQ-011 SHALL have port id_valid, output, 1, decode-side entry valid.
REQ-012 SHALL have port id_ready, input, 1, decode accepts entry.
REQ-013 SHALL have port id_instr, output, 32, instruction at buffer head.
REQ-014 SHALL have port id_pc, output, 32, PC of the head instruction.
REQ-015 SHALL have port id_imm_field, output, 24, instr[31:8] of the head entry, wired to the immediate extender's 24-bit input.
REQ-016 SHALL have port id_imm_src, output, 3, immediate format: 3'b000 for opcode 7'b0110111/7'b0010111 (U); 3'b001 for 7'b0010011/7'b0000011/7'b1100111 (I); 3'b111 otherwise.

Function
REQ-017 SHALL hold a fetch PC register; imem_req_addr = {pc[31:2],2'b00}.
REQ-018 SHALL hold a 2-entry FIFO of {instr, pc}; id_* outputs show the head entry combinationally; id_valid = (count != 0).
REQ-019 SHALL permit at most one outstanding request; FSM states IDLE, WAIT, DROP.
REQ-020 IDLE: imem_req_valid = 1 iff count + (entry popped this cycle ? -1 : 0) < 2; on req_valid & req_ready, SHALL latch the request PC, set pc <= pc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), and go to WAIT.
REQ-021 WAIT: imem_req_valid = 0; on imem_resp_valid, SHALL push {imem_resp_data, latched PC} and go to IDLE; zero-bubble push in same cycle as pop SHALL be allowed.
REQ-022 Pop SHALL occur on id_valid & id_ready; push and pop in the same cycle with count==2 SHALL succeed (count unchanged).
REQ-023 On redirect_valid, SHALL flush the FIFO (count <= 0), set pc <= {redirect_pc[31:2],2'b00}, and block any request that cycle.
REQ-024 Redirect in IDLE or WAIT-with-response-same-cycle SHALL go to IDLE and discard that response; redirect in WAIT without a response SHALL go to DROP.
REQ-025 DROP: imem_req_valid = 0; the next imem_resp_valid SHALL be discarded and the FSM SHALL go to IDLE; another redirect in DROP SHALL update pc and stay in DROP.
REQ-026 imem_resp_valid in IDLE (no outstanding request) SHALL be ignored.
REQ-027 Redirect and id handshake in the same cycle: the flush SHALL take priority; the pop is irrelevant.
REQ-028 Fetch-path latency: request accept at cycle N, response at N+k, id_valid high at N+k+1.

Reset
REQ-029 While reset=1: pc = RESET_PC, FIFO count = 0, FSM = IDLE, id_valid = 0, imem_req_valid = 0; FIFO data contents are don't-care.
REQ-030 Reset asserted mid-WAIT SHALL abandon the request; the first response after deassertion SHALL be ignored (FSM in IDLE).
REQ-031 imem_req_valid SHALL rise no earlier than the first clock edge after reset deassertion.

Verification
REQ-032 Reset release, memory always ready, 1-cycle response with data 32'h00000013 -> addresses 0,4,8 issued; id_pc 0,4,8 with id_instr 32'h00000013; id_imm_src=3'b001.
REQ-033 id_ready=0 for 10 cycles -> exactly 2 entries buffered (pc 0,4); req_valid low; on release, pc 0,4 pop in order with no loss.
REQ-034 Redirect to 32'h00000102 while in WAIT for addr 8 -> response for 8 dropped; next request addr 32'h00000100; id_pc 32'h100 first.
REQ-035 Redirect in the same cycle as a response -> response discarded, FIFO empty next cycle, next request addr = redirect target.
REQ-036 RESET_PC=32'hFFFFFFFC -> requests 32'hFFFFFFFC then 32'h00000000.
REQ-037 Response 32'h123450B7 (LUI) -> id_imm_src=3'b000, id_imm_field=24'h123450.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front end. It keeps one request outstanding to instruction
// memory and holds the returned words in a 2-entry queue for the decode stage.
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [23:0] id_imm_field,
  output logic [2:0]  id_imm_src
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fb_entry_t;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        req_pc_q, req_pc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   started_q, started_d;
  fb_entry_t              mem_q [DEPTH];
  fb_entry_t              mem_d [DEPTH];

  logic                   pop_c;
  logic                   push_c;
  logic                   fire_c;
  logic                   req_valid_c;
  logic [CNT_W-1:0]       occ_after_pop_c;
  fb_entry_t              head_c;
  logic [6:0]             opcode_c;

  // Next-state, request gating and queue bookkeeping.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_pc_d        = req_pc_q;
    count_d         = count_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    started_d       = 1'b1;
    mem_d           = mem_q;
    req_valid_c     = 1'b0;
    push_c          = 1'b0;

    pop_c           = (count_q != '0) && id_ready && !redirect_valid;
    occ_after_pop_c = count_q - CNT_W'(pop_c);

    if (state_q == S_IDLE && started_q && !redirect_valid &&
        occ_after_pop_c < CNT_W'(DEPTH)) begin
      req_valid_c = 1'b1;
    end
    fire_c = req_valid_c && imem_req_ready;

    case (state_q)
      S_IDLE: begin
        if (fire_c) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_resp_valid ? S_IDLE : S_DROP;
        end else if (imem_resp_valid) begin
          push_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        // The stale response retires the drop even if another redirect lands with it.
        if (imem_resp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push_c) begin
      mem_d[wr_ptr_q] = '{instr: imem_resp_data, pc: req_pc_q};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // Redirect flushes the queue and overrides any fetch-PC advance.
    if (redirect_valid) begin
      pc_d     = redirect_pc & ALIGN_MASK;
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC & ALIGN_MASK;
      req_pc_q  <= '0;
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      started_q <= started_d;
    end
  end

  // Queue payload needs no reset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head-of-queue view and immediate-format decode for the decode stage.
  always_comb begin
    head_c   = mem_q[rd_ptr_q];
    opcode_c = head_c.instr[6:0];
    case (opcode_c)
      7'b0110111, 7'b0010111:             id_imm_src = 3'b000;
      7'b0010011, 7'b0000011, 7'b1100111: id_imm_src = 3'b001;
      default:                            id_imm_src = 3'b111;
    endcase
  end

  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = pc_q;
  assign id_valid       = (count_q != '0);
  assign id_instr       = head_c.instr;
  assign id_pc          = head_c.pc;
  assign id_imm_field   = head_c.instr[31:8];

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer; a second instance checks PC wrap from 32'hFFFFFFFC.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [23:0] id_imm_field;
  logic [2:0]  id_imm_src;

  logic        imem_req_valid_2;
  logic [31:0] imem_req_addr_2;
  logic        id_valid_2;
  logic [31:0] id_instr_2;
  logic [31:0] id_pc_2;
  logic [23:0] id_imm_field_2;
  logic [2:0]  id_imm_src_2;

  int n_vec;
  int n_err;

  instr_fetch_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_imm_field(id_imm_field),
    .id_imm_src(id_imm_src)
  );

  instr_fetch_buffer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid_2), .imem_req_addr(imem_req_addr_2),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid_2), .id_ready(id_ready),
    .id_instr(id_instr_2), .id_pc(id_pc_2), .id_imm_field(id_imm_field_2),
    .id_imm_src(id_imm_src_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic redv, input logic [31:0] rpc, input logic idr);
    @(negedge clk);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    redirect_valid  = redv;
    redirect_pc     = rpc;
    id_ready        = idr;
    #1;
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    id_ready        = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    id_ready        = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    n_vec++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 00000000", imem_req_addr); end
    n_vec++; if (imem_req_addr_2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_addr_wrap got %h want fffffffc", imem_req_addr_2); end
    @(negedge clk);
    reset = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL req_before_first_edge got %b want 0", imem_req_valid); end
    // A response with nothing outstanding must not enter the queue.
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b0);
    n_vec++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL req_after_first_edge got %b want 1", imem_req_valid); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL idle_resp_ignored got %b want 0", id_valid); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_wrap;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      exp_wrap = 32'hFFFF_FFFC + 32'(4 * i);
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
      n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin n_err++; $display("FAIL basic_req[%0d] got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_req_addr, 32'(4 * i)); end
      n_vec++; if (imem_req_addr_2 !== exp_wrap) begin n_err++; $display("FAIL wrap_req[%0d] got %h want %h", i, imem_req_addr_2, exp_wrap); end
      if (i > 0) begin
        n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * (i - 1)) || id_instr !== 32'h0000_0013 || id_imm_src !== 3'b001) begin
          n_err++; $display("FAIL basic_id[%0d] got v=%b pc=%h instr=%h src=%b want v=1 pc=%h instr=00000013 src=001", i, id_valid, id_pc, id_instr, id_imm_src, 32'(4 * (i - 1)));
        end
      end
      drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b1);
      n_vec++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait[%0d] got req=%b idv=%b want 0 0", i, imem_req_valid, id_valid); end
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin n_err++; $display("FAIL basic_last got v=%b pc=%h want v=1 pc=00000008", id_valid, id_pc); end
  endtask

  task automatic test_backpressure();
    logic outst;
    int   fires;
    outst = 1'b0;
    fires = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, outst, 32'h0000_0013, 1'b0, '0, 1'b0);
      outst = imem_req_valid & imem_req_ready;
      if (outst) fires++;
    end
    n_vec++; if (fires !== 2) begin n_err++; $display("FAIL bp_fetch_count got %0d want 2", fires); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_full got %b want 0", imem_req_valid); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_err++; $display("FAIL bp_pop0 got v=%b pc=%h want v=1 pc=00000000", id_valid, id_pc); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin n_err++; $display("FAIL bp_pop1 got v=%b pc=%h want v=1 pc=00000004", id_valid, id_pc); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", id_valid); end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_err++; $display("FAIL rw_req8 got v=%b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
    drive(1'b1, 1'b0, '0, 1'b1, 32'h0000_0102, 1'b1);
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_redirect_block got %b want 0", imem_req_valid); end
    drive(1'b1, 1'b1, 32'hDEAD_0013, 1'b0, '0, 1'b1);
    n_vec++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop got req=%b idv=%b want 0 0", imem_req_valid, id_valid); end
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rw_stale_dropped got %b want 0", id_valid); end
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_err++; $display("FAIL rw_req_target got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_err++; $display("FAIL rw_first_pc got v=%b pc=%h want v=1 pc=00000100", id_valid, id_pc); end
  endtask

  task automatic test_redirect_resp();
    apply_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0013, 1'b1, 32'h0000_0040, 1'b0);
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rr_block got %b want 0", imem_req_valid); end
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rr_discard got %b want 0", id_valid); end
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin n_err++; $display("FAIL rr_req_target got v=%b a=%h want v=1 a=00000040", imem_req_valid, imem_req_addr); end
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b0);
    // Redirect together with a pop: the flush wins.
    drive(1'b1, 1'b0, '0, 1'b1, 32'h0000_0080, 1'b1);
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin n_err++; $display("FAIL rr_head got v=%b pc=%h want v=1 pc=00000040", id_valid, id_pc); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rr_block2 got %b want 0", imem_req_valid); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin n_err++; $display("FAIL rr_flush got idv=%b req=%b a=%h want 0 1 00000080", id_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_err++; $display("FAIL rmw_in_reset got req=%b idv=%b want 0 0", imem_req_valid, id_valid); end
    @(negedge clk);
    reset = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rmw_release_req got %b want 0", imem_req_valid); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rmw_after got idv=%b req=%b a=%h want 0 1 00000000", id_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_imm_decode();
    apply_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'h1234_50B7, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    n_vec++; if (id_imm_src !== 3'b000 || id_imm_field !== 24'h123450 || id_instr !== 32'h1234_50B7) begin
      n_err++; $display("FAIL lui got src=%b field=%h instr=%h want 000 123450 123450b7", id_imm_src, id_imm_field, id_instr);
    end
    drive(1'b0, 1'b1, 32'h00B5_0533, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++; if (id_imm_src !== 3'b111 || id_imm_field !== 24'h00B505 || id_pc !== 32'h4) begin
      n_err++; $display("FAIL rtype got src=%b field=%h pc=%h want 111 00b505 00000004", id_imm_src, id_imm_field, id_pc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_reset_mid_wait();
    test_imm_decode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
